// File: rtl/axi_w_fifo_drain_if.sv
// AXI4 write-data (W) channel bundle between the FIFO drain (master) and the slave.
interface axi_w_fifo_drain_if #(
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W/8
);
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WLAST;
   logic              WVALID;
   logic              WREADY;

   modport master (output WDATA, WSTRB, WLAST, WVALID, input WREADY);
   modport slave  (input WDATA, WSTRB, WLAST, WVALID, output WREADY);
endinterface

// File: rtl/axi_w_fifo_drain.sv
// Pops exactly one AXI W burst (len+1 packed beats) from an FWFT FIFO into a 2-entry skid buffer.
// Define WLAST_CHECK_EN to drive WLAST from the beat count and flag packed-WLAST mismatches.
module axi_w_fifo_drain #(
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W/8,
   parameter int PKT_W  = DATA_W+STRB_W+1,
   parameter int LEN_W  = 4
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic [PKT_W-1:0]   fifo_rdata,
   input  logic               fifo_rempty,
   output logic               fifo_rpop,
   input  logic               bl_valid,
   input  logic [LEN_W-1:0]   bl_len,
   output logic               bl_ready,
   axi_w_fifo_drain_if.master w,
   output logic               burst_done,
   output logic               wlast_err
);
   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W:0]   r_pop_cnt;
   logic [LEN_W:0]   r_beat_cnt;
   logic [1:0]       r_cnt;
   logic [PKT_W-1:0] r_buf0;
   logic [PKT_W-1:0] r_buf1;

   logic w_valid;
   logic w_hs;
   logic w_is_last;
   logic w_last_hs;

   assign bl_ready   = (r_state == S_IDLE);
   assign w_valid    = (r_cnt != 2'd0);
   assign w_hs       = w_valid && w.WREADY;
   assign w_is_last  = (r_beat_cnt == {1'b0, r_len});
   assign w_last_hs  = w_hs && w_is_last;
   assign burst_done = w_last_hs;

   // Never fetch past the burst's last beat, so the next burst's data stays in the FIFO.
   assign fifo_rpop  = (r_state == S_BURST) && !fifo_rempty && (r_cnt < 2'd2) &&
                       (r_pop_cnt <= {1'b0, r_len});

   assign w.WVALID   = w_valid;
   assign w.WDATA    = r_buf0[PKT_W-1 -: DATA_W];
   assign w.WSTRB    = r_buf0[STRB_W:1];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_pop_cnt  <= '0;
         r_beat_cnt <= '0;
         r_cnt      <= 2'd0;
         r_buf0     <= '0;
         r_buf1     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bl_valid) begin
                  r_len      <= bl_len;
                  r_pop_cnt  <= '0;
                  r_beat_cnt <= '0;
                  r_state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (fifo_rpop) r_pop_cnt <= r_pop_cnt + CNT_ONE;
               if (w_hs)      r_beat_cnt <= r_beat_cnt + CNT_ONE;
               if (w_last_hs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Head is r_buf0; a simultaneous pop and retire keeps occupancy for 1 beat/cycle.
         case ({fifo_rpop, w_hs})
            2'b10: begin
               if (r_cnt == 2'd0) r_buf0 <= fifo_rdata;
               else               r_buf1 <= fifo_rdata;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_cnt  <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd2) begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= fifo_rdata;
               end else begin
                  r_buf0 <= fifo_rdata;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WLAST_CHECK_EN
   logic r_wlast_err;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)
         r_wlast_err <= 1'b0;
      else if (w_hs && (r_buf0[0] != w_is_last))
         r_wlast_err <= 1'b1;
   end

   assign wlast_err = r_wlast_err;
   assign w.WLAST   = w_valid && w_is_last;
`else
   assign wlast_err = 1'b0;
   assign w.WLAST   = r_buf0[0];
`endif
endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// Bench for axi_w_fifo_drain: FWFT FIFO model, expected-beat scoreboard, table of burst scenarios.
`timescale 1ns/1ps
module tb_axi_w_fifo_drain;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int PKT_W  = DATA_W + STRB_W + 1;
   localparam int LEN_W  = 4;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   // len, beats present at start, beats total, refill cycle, WREADY pattern, data base,
   // packed WLAST on beat 0, hold bl_valid, first WVALID cycle, done cycle, gap expected, full expected
   typedef struct {
      int          len;
      int          n_init;
      int          n_fifo;
      int          refill_at;
      logic [15:0] rdy;
      logic [31:0] base;
      bit          bad_last;
      bit          hold_bl;
      int          exp_first;
      int          exp_done;
      bit          exp_gap;
      bit          exp_full;
   } vec_t;

   logic             ACLK = 1'b0;
   logic             ARESETn;
   logic [PKT_W-1:0] fifo_rdata;
   logic             fifo_rempty;
   logic             fifo_rpop;
   logic             bl_valid;
   logic [LEN_W-1:0] bl_len;
   logic             bl_ready;
   logic             burst_done;
   logic             wlast_err;

   axi_w_fifo_drain_if #(.DATA_W(DATA_W), .STRB_W(STRB_W)) wif();

   axi_w_fifo_drain #(
      .DATA_W(DATA_W), .STRB_W(STRB_W), .PKT_W(PKT_W), .LEN_W(LEN_W)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rpop(fifo_rpop),
      .bl_valid(bl_valid), .bl_len(bl_len), .bl_ready(bl_ready),
      .w(wif.master),
      .burst_done(burst_done), .wlast_err(wlast_err)
   );

   always #5 ACLK = ~ACLK;

   logic [PKT_W-1:0] fifo_q[$];
   logic [PKT_W-1:0] pend[$];
   beat_t            exp_q[$];

   int    n_err = 0;
   int    n_chk = 0;
   string cur_name = "init";

   int n_pop, n_hs, n_done, occ, max_occ;
   int v_rpop_empty, v_stab, v_occ, v_blr;
   bit stall_prev;
   logic [PKT_W-1:0] prev_out;
   logic s_wvalid, s_done, s_blready, s_rpop, s_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_rempty = (fifo_q.size() == 0);
      fifo_rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic clear_stats();
      n_pop = 0; n_hs = 0; n_done = 0; occ = 0; max_occ = 0;
      v_rpop_empty = 0; v_stab = 0; v_occ = 0; v_blr = 0;
      stall_prev = 1'b0;
   endtask

   // One clock: observe the cycle at the falling edge, then advance the FIFO model after the rising edge.
   task automatic step();
      logic  pop_s;
      beat_t e;
      @(negedge ACLK);
      pop_s     = fifo_rpop;
      s_wvalid  = wif.WVALID;
      s_done    = burst_done;
      s_blready = bl_ready;
      s_rpop    = fifo_rpop;
      s_err     = wlast_err;
      if (fifo_rpop && fifo_rempty) v_rpop_empty++;
      if (stall_prev && (!wif.WVALID || ({wif.WDATA, wif.WSTRB, wif.WLAST} != prev_out))) v_stab++;
      stall_prev = wif.WVALID && !wif.WREADY;
      prev_out   = {wif.WDATA, wif.WSTRB, wif.WLAST};
      if (fifo_rpop) begin n_pop++; occ++; end
      if (wif.WVALID && wif.WREADY) begin
         n_hs++;
         occ--;
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s extra_beat: got %0h, want no beat", cur_name,
                     {wif.WDATA, wif.WSTRB, wif.WLAST});
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s beat%0d", cur_name, n_hs - 1),
                {27'b0, wif.WDATA, wif.WSTRB, wif.WLAST}, {27'b0, e.d, e.s, e.l});
         end
      end
      if (occ > max_occ) max_occ = occ;
      if (occ > 2 || occ < 0) v_occ++;
      if (burst_done) n_done++;
      @(posedge ACLK);
      #1;
      if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic run_row(input vec_t v, input string nm);
      beat_t       e;
      logic [31:0] d;
      logic [3:0]  s;
      logic        pl;
      int          first, done, vlow;
      bit          exp_err;
      cur_name = nm;
      clear_stats();
      pend.delete();
      for (int i = 0; i < v.n_fifo; i++) begin
         d  = v.base + 32'(i) * 32'h01010101;
         s  = v.base[3:0] ^ 4'(i);
         pl = v.bad_last ? (i == 0) : (i == v.len);
         if (i < v.n_init) fifo_q.push_back({d, s, pl});
         else              pend.push_back({d, s, pl});
         if (i <= v.len) begin
            e.d = d;
            e.s = s;
`ifdef WLAST_CHECK_EN
            e.l = (i == v.len);
`else
            e.l = pl;
`endif
            exp_q.push_back(e);
         end
      end
      drive_fifo();
      bl_len      = LEN_W'(v.len);
      bl_valid    = 1'b1;
      wif.WREADY  = v.rdy[0];
      step();
      chk({nm, " bl_ready_idle"}, 64'(s_blready), 64'd1);
      first = -1; done = -1; vlow = 0;
      for (int t = 1; t <= 300 && done < 0; t++) begin
         bl_valid   = v.hold_bl;
         bl_len     = LEN_W'(v.len) ^ 4'hA;
         wif.WREADY = v.rdy[t % 16];
         if (t == v.refill_at) begin
            while (pend.size() > 0) fifo_q.push_back(pend.pop_front());
            drive_fifo();
         end
         step();
         if (s_blready) v_blr++;
         if (s_wvalid && first < 0) first = t;
         if (!s_wvalid && first >= 0) vlow++;
         if (s_done) done = t;
      end
      bl_valid   = 1'b0;
      wif.WREADY = 1'b1;
      if (done < 0) begin
         n_chk++; n_err++;
         $display("FAIL %s timeout: got no burst_done, want one within 300 cycles", nm);
      end
      step();
      chk({nm, " bl_ready_after"}, 64'(s_blready), 64'd1);
      chk({nm, " rpop_after"},     64'(s_rpop), 64'd0);
      chk({nm, " pops"},           64'(n_pop), 64'(v.len + 1));
      chk({nm, " beats"},          64'(n_hs), 64'(v.len + 1));
      chk({nm, " done_pulses"},    64'(n_done), 64'd1);
      chk({nm, " fifo_left"},      64'(fifo_q.size() + pend.size()), 64'(v.n_fifo - v.len - 1));
      chk({nm, " exp_left"},       64'(exp_q.size()), 64'd0);
      chk({nm, " rpop_empty"},     64'(v_rpop_empty), 64'd0);
      chk({nm, " stable"},         64'(v_stab), 64'd0);
      chk({nm, " occupancy"},      64'(v_occ), 64'd0);
      chk({nm, " bl_ready_busy"},  64'(v_blr), 64'd0);
      chk({nm, " gap"},            64'(vlow > 0), 64'(v.exp_gap));
`ifdef WLAST_CHECK_EN
      exp_err = v.bad_last;
`else
      exp_err = 1'b0;
`endif
      chk({nm, " wlast_err"}, 64'(s_err), 64'(exp_err));
      if (v.exp_first >= 0) chk({nm, " first_cycle"}, 64'(first), 64'(v.exp_first));
      if (v.exp_done >= 0)  chk({nm, " done_cycle"},  64'(done), 64'(v.exp_done));
      if (v.exp_full)       chk({nm, " max_occ"},     64'(max_occ), 64'd2);
      fifo_q.delete();
      pend.delete();
      exp_q.delete();
      drive_fifo();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[7];
      vec_t vr;
      vt[0] = '{0,  1,  1,  0, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 2,  2, 1'b0, 1'b0};
      vt[1] = '{3,  6,  6,  0, 16'hFFFF, 32'h11110000, 1'b0, 1'b0, 2,  5, 1'b0, 1'b0};
      vt[2] = '{7,  8,  8,  0, 16'h9999, 32'h22220000, 1'b0, 1'b0, 2, -1, 1'b0, 1'b1};
      vt[3] = '{3,  1,  4,  7, 16'hFFFF, 32'h33330000, 1'b0, 1'b0, 2, 10, 1'b1, 1'b0};
      vt[4] = '{15, 16, 16, 0, 16'hFFFF, 32'h44440000, 1'b0, 1'b0, 2, 17, 1'b0, 1'b0};
      vt[5] = '{15, 20, 20, 0, 16'hB6D3, 32'h55550000, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0};
      vt[6] = '{1,  2,  2,  0, 16'hFFFF, 32'h66660000, 1'b1, 1'b0, 2,  3, 1'b0, 1'b0};

      ARESETn    = 1'b0;
      bl_valid   = 1'b0;
      bl_len     = '0;
      wif.WREADY = 1'b0;
      drive_fifo();
      clear_stats();
      #1;
      chk("rst wvalid",     64'(wif.WVALID), 64'd0);
      chk("rst rpop",       64'(fifo_rpop), 64'd0);
      chk("rst bl_ready",   64'(bl_ready), 64'd1);
      chk("rst burst_done", 64'(burst_done), 64'd0);
      chk("rst wlast_err",  64'(wlast_err), 64'd0);
      chk("rst wout",       64'({wif.WDATA, wif.WSTRB, wif.WLAST}), 64'd0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      step();

      for (int r = 0; r < 7; r++) run_row(vt[r], $sformatf("row%0d", r));

      repeat (3) step();
`ifdef WLAST_CHECK_EN
      chk("wlast_err sticky", 64'(wlast_err), 64'd1);
`else
      chk("wlast_err sticky", 64'(wlast_err), 64'd0);
`endif

      // Reset in the middle of a stalled burst with both buffer entries full.
      cur_name = "midrst";
      clear_stats();
      for (int i = 0; i < 8; i++) fifo_q.push_back({32'hA5A50000 + 32'(i), 4'h3, (i == 7)});
      drive_fifo();
      bl_len     = 4'd7;
      bl_valid   = 1'b1;
      wif.WREADY = 1'b0;
      step();
      bl_valid = 1'b0;
      repeat (3) step();
      chk("midrst pre_wvalid", 64'(s_wvalid), 64'd1);
      chk("midrst pre_pops",   64'(n_pop), 64'd2);
      ARESETn = 1'b0;
      #1;
      chk("midrst wvalid",    64'(wif.WVALID), 64'd0);
      chk("midrst rpop",      64'(fifo_rpop), 64'd0);
      chk("midrst bl_ready",  64'(bl_ready), 64'd1);
      chk("midrst wlast_err", 64'(wlast_err), 64'd0);
      fifo_q.delete();
      exp_q.delete();
      drive_fifo();
      clear_stats();
      step();
      ARESETn = 1'b1;
      step();
      vr = '{0, 1, 1, 0, 16'hFFFF, 32'h77770000, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};
      run_row(vr, "postrst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
